// File: rtl/ex_stall_ctrl.sv
// EX-stage stall/flush controller: multi-cycle MUL, load-use hazard and taken-branch flush.
// Optional stall counter output enabled by defining EX_STALL_CNT_EN.
module ex_stall_ctrl #(
  parameter int unsigned MUL_LATENCY = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       ex_valid,
  input  logic [1:0] ex_ALUOp,
  input  logic [5:0] ex_funct,
  input  logic       ex_mem_read,
  input  logic [4:0] ex_rt_num,
  input  logic       id_valid,
  input  logic [4:0] id_rs_num,
  input  logic [4:0] id_rt_num,
  input  logic       branch,
  input  logic       zero,
  output logic       stall_flag,
  output logic       flush,
  output logic       pc_write,
  output logic       ifid_write,
  output logic       mul_done
`ifdef EX_STALL_CNT_EN
  ,
  output logic [15:0] stall_cnt
`endif
);

  localparam logic [1:0] S_IDLE    = 2'b00;
  localparam logic [1:0] S_MUL     = 2'b01;
  localparam logic [1:0] S_LOADUSE = 2'b10;
  localparam logic [1:0] S_FLUSH   = 2'b11;

  localparam logic [3:0] MUL_INIT = 4'(MUL_LATENCY - 1);

  logic [1:0] state_q, state_d;
  logic [3:0] cnt_q, cnt_d;
  logic       done1_q, done1_d;

  logic taken, mul_start, load_use;

  assign taken     = ex_valid && branch && zero;
  assign mul_start = ex_valid && (ex_ALUOp == 2'b10) && (ex_funct == 6'b000010);
  assign load_use  = ex_valid && ex_mem_read && id_valid && (ex_rt_num != 5'd0) &&
                     ((ex_rt_num == id_rs_num) || (ex_rt_num == id_rt_num));

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    done1_d = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (taken) begin
          state_d = S_FLUSH;
        end else if (mul_start) begin
          // A single-cycle MUL never stalls; it only reports completion next cycle.
          if (MUL_LATENCY > 1) begin
            state_d = S_MUL;
            cnt_d   = MUL_INIT;
          end else begin
            done1_d = 1'b1;
          end
        end else if (load_use) begin
          state_d = S_LOADUSE;
        end
      end
      S_MUL: begin
        cnt_d = cnt_q - 4'd1;
        if (cnt_q <= 4'd1) begin
          state_d = S_IDLE;
        end
      end
      S_LOADUSE: state_d = S_IDLE;
      S_FLUSH:   state_d = S_IDLE;
      default: begin
        state_d = S_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      done1_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      done1_q <= done1_d;
    end
  end

  assign stall_flag = (state_q == S_MUL) || (state_q == S_LOADUSE);
  assign flush      = (state_q == S_FLUSH);
  assign pc_write   = ~stall_flag;
  assign ifid_write = ~stall_flag;
  assign mul_done   = ((state_q == S_MUL) && (cnt_q == 4'd1)) || done1_q;

`ifdef EX_STALL_CNT_EN
  logic [15:0] stall_cnt_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stall_cnt_q <= '0;
    end else if (stall_flag && (stall_cnt_q != '1)) begin
      stall_cnt_q <= stall_cnt_q + 16'd1;
    end
  end

  assign stall_cnt = stall_cnt_q;
`endif

endmodule

// File: doc/ex_stall_ctrl.md
EX_STALL_CTRL -- requirements
Module: ex_stall_ctrl

Interface
REQ-001 SHALL have parameter MUL_LATENCY, default 4: total EX cycles of MUL op; legal range 1..16.
REQ-002 SHALL have port clk  input  1  sole clock, all state updates on rising edge.
REQ-003 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-004 SHALL have port ex_valid  input  1  EX stage holds a valid instruction.
REQ-005 SHALL have port ex_ALUOp  input  2  ALUOp of EX instruction (00 LW/SW/ADDI, 01 BEQ, 10 RType).
REQ-006 SHALL have port ex_funct  input  6  funct of EX instruction (000010 = MUL).
REQ-007 SHALL have port ex_mem_read  input  1  EX instruction is a load.
REQ-008 SHALL have port ex_rt_num  input  5  destination register number of EX load.
REQ-009 SHALL have port id_valid  input  1  ID stage holds a valid instruction.
REQ-010 SHALL have ports id_rs_num, id_rt_num  input  5 each  source register numbers in ID.
REQ-011 SHALL have ports branch, zero  input  1 each  EX branch flag and ALU zero result.
REQ-012 SHALL have port stall_flag  output  1  freezes EX/ID/IF when high.
REQ-013 SHALL have port flush  output  1  squashes IF/ID contents when high.
REQ-014 SHALL have ports pc_write, ifid_write  output  1 each  enables; always equal to ~stall_flag.
REQ-015 SHALL have port mul_done  output  1  one-cycle pulse on MUL completion.

Function
REQ-016 SHALL implement FSM states IDLE, MUL, LOADUSE, FLUSH; all outputs decoded from registered state/counter only (no combinational input-to-output path).
REQ-017 stall_flag SHALL be 1 exactly in MUL and LOADUSE; flush SHALL be 1 exactly in FLUSH.
REQ-018 In IDLE, priority: taken branch > MUL start > load-use; only one transition per cycle.
REQ-019 Taken branch: ex_valid & branch & zero in IDLE -> FLUSH next cycle; FLUSH -> IDLE after 1 cycle.
REQ-020 MUL start: ex_valid & ex_ALUOp==10 & ex_funct==000010 in IDLE with MUL_LATENCY>1 -> MUL, 4-bit counter loaded with MUL_LATENCY-1.
REQ-021 In MUL counter SHALL decrement each cycle; when counter==1 next state IDLE and mul_done pulses during that final MUL cycle; stall therefore lasts exactly MUL_LATENCY-1 cycles.
REQ-022 MUL_LATENCY==1: MUL op SHALL cause no stall; mul_done pulses for one cycle beginning the cycle after detection.
REQ-023 Load-use: ex_valid & ex_mem_read & id_valid & ex_rt_num!=0 & (ex_rt_num==id_rs_num | ex_rt_num==id_rt_num) in IDLE -> LOADUSE for exactly 1 cycle, then IDLE.
REQ-024 ex_rt_num==0 SHALL never trigger load-use stall.
REQ-025 All inputs SHALL be ignored while in MUL, LOADUSE or FLUSH; detection resumes on first IDLE cycle.
REQ-026 Back-to-back events: a condition still present on the first IDLE cycle after a stall SHALL be re-evaluated and may re-enter a state.
REQ-027 Unreachable state encodings SHALL return to IDLE next cycle with all outputs at reset values.

Reset
REQ-028 Reset assertion SHALL immediately (asynchronously) force IDLE, counter 0, stall_flag 0, flush 0, pc_write 1, ifid_write 1, mul_done 0, stall_cnt 0.
REQ-029 Reset mid-MUL or mid-LOADUSE SHALL abandon the operation with no mul_done pulse.
REQ-030 First state evaluation SHALL occur on the first rising clk edge after reset deasserts.

Configuration
REQ-031 Macro EX_STALL_CNT_EN, when defined, SHALL add output stall_cnt (16 bits): increments each cycle stall_flag==1, saturates at 0xFFFF, cleared only by reset.
REQ-032 Without EX_STALL_CNT_EN the port and counter SHALL be absent; all other behaviour identical.

Verification
REQ-033 Reset high then low, all inputs 0 -> stall_flag 0, flush 0, pc_write 1, state IDLE for 10 cycles.
REQ-034 MUL_LATENCY=4, one-cycle ex_valid, ALUOp=10, funct=000010 -> stall_flag high exactly 3 cycles, mul_done high on 3rd of them.
REQ-035 Load ex_rt_num=5, id_rs_num=5, both valid -> stall_flag high exactly 1 cycle; repeat with ex_rt_num=0 -> no stall.
REQ-036 Same cycle: taken branch (branch=1, zero=1) plus MUL plus load-use -> FLUSH for 1 cycle, no stall; branch with zero=0 -> no flush.
REQ-037 Reset asserted on 2nd cycle of MUL -> outputs reset immediately, no mul_done; with EX_STALL_CNT_EN, stall_cnt reads 0.
REQ-038 With EX_STALL_CNT_EN, 70000 consecutive MUL ops (MUL_LATENCY=2) -> stall_cnt saturates at 0xFFFF.
